// File: rtl/matrix_fb_arbiter.sv
// ---------------------------------------------------------------------------
// matrix_fb_arbiter
//
// Frame store and row-scan driver for the 8x8 LED matrix. Three game agents
// (0 = player logic, 1 = boss logic, 2 = win/lose overlay) write pixels into
// a back buffer through a small arbiter. The scan always reads a separate
// front buffer. The back buffer is copied into the front buffer only when
// the scan wraps from row 7 to row 0, so a frame is never shown half-drawn.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   req[2:0]     per-agent write request, bit i = agent i
//   op[5:0]      per-agent opcode, agent i at [2i+1:2i]
//                  00 clear pixel, 01 set pixel, 10 clear row y, 11 clear all
//   addr[17:0]   per-agent address, agent i at [6i+5:6i] = {y[2:0], x[2:0]}
//   gnt[2:0]     one-hot registered grant, high for exactly one cycle
//   swap_req     one-cycle pulse asking for a back-to-front commit
//   swap_done    one-cycle pulse in the cycle after the commit edge
//   frame_start  one-cycle pulse in the cycle after the scan wraps 7 -> 0
//   segout[7:0]  active-low pixels of the displayed row, bit x lit = 0
//   scanout[2:0] index y of the displayed row
//
// Buffers hold 64 bits each, bit index = 8*y + x, 1 = lit.
// ---------------------------------------------------------------------------
module matrix_fb_arbiter #(
    parameter int SCAN_DIV = 8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [5:0]  op,
    input  logic [17:0] addr,
    output logic [2:0]  gnt,
    input  logic        swap_req,
    output logic        swap_done,
    output logic        frame_start,
    output logic [7:0]  segout,
    output logic [2:0]  scanout
);

    // Prescaler width; SCAN_DIV is at least 2 so this is at least 1 bit.
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Arbiter state
    arb_state_t      state_q, state_d;
    logic [2:0]      gnt_q, gnt_d;
    // Agent (0 or 1) that wins the next tie between agents 0 and 1.
    logic            rr_ptr_q, rr_ptr_d;

    // Frame store
    logic [63:0]     back_q, back_d;
    logic [63:0]     front_q, front_d;

    // Scan and swap bookkeeping
    logic [PW-1:0]   prescale_q, prescale_d;
    logic [2:0]      scan_q, scan_d;
    logic [7:0]      segout_q, segout_d;
    logic            pending_q, pending_d;
    logic            swap_done_q, swap_done_d;
    logic            frame_start_q, frame_start_d;

    // Decoded winner request and scan events
    logic [1:0]      win_op;
    logic [5:0]      win_addr;
    logic            scan_tick;
    logic            frame_wrap;
    logic            commit;

    // -----------------------------------------------------------------------
    // Arbiter next-state logic. A grant is decided in IDLE from the live req
    // vector and registered, so gnt is high for the single GRANT cycle that
    // follows. The overlay agent always wins; agents 0 and 1 alternate when
    // both ask, and the tie pointer only moves when one of them is served.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        gnt_d    = 3'b000;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    state_d = GRANT;
                    if (req[2]) begin
                        gnt_d = 3'b100;
                    end else if (req[1:0] == 2'b11) begin
                        gnt_d    = rr_ptr_q ? 3'b010 : 3'b001;
                        rr_ptr_d = ~rr_ptr_q;
                    end else if (req[0]) begin
                        gnt_d    = 3'b001;
                        rr_ptr_d = 1'b1;
                    end else begin
                        gnt_d    = 3'b010;
                        rr_ptr_d = 1'b0;
                    end
                end
            end
            GRANT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Select the granted agent's opcode and address. The requester holds
    // them stable through the GRANT cycle, so they are read live here.
    // -----------------------------------------------------------------------
    always_comb begin
        win_op   = op[1:0];
        win_addr = addr[5:0];
        if (gnt_q[2]) begin
            win_op   = op[5:4];
            win_addr = addr[17:12];
        end else if (gnt_q[1]) begin
            win_op   = op[3:2];
            win_addr = addr[11:6];
        end
    end

    // -----------------------------------------------------------------------
    // Back buffer update: the granted write lands on the edge that ends the
    // GRANT cycle. A reset during GRANT clears the state before that edge,
    // so an interrupted write is simply lost.
    // -----------------------------------------------------------------------
    always_comb begin
        back_d = back_q;
        if (state_q == GRANT) begin
            case (win_op)
                2'b00:   back_d[win_addr] = 1'b0;
                2'b01:   back_d[win_addr] = 1'b1;
                2'b10:   back_d[{win_addr[5:3], 3'b000} +: 8] = 8'h00;
                default: back_d = 64'd0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Row scan and frame commit. The prescaler sets the row period; at its
    // terminal count the row advances and segout reloads. The commit takes
    // the post-write back buffer, so a write landing on the wrap edge is
    // part of the new frame, and row 0 is loaded from the new front buffer.
    // A swap_req arriving while one is pending (including on the commit
    // edge itself) is absorbed into that commit.
    // -----------------------------------------------------------------------
    always_comb begin
        scan_tick  = (prescale_q == PRESCALE_LAST);
        frame_wrap = scan_tick && (scan_q == 3'd7);
        commit     = frame_wrap && pending_q;

        prescale_d = scan_tick ? '0 : prescale_q + PW'(1);
        scan_d     = scan_tick ? scan_q + 3'd1 : scan_q;

        front_d    = commit ? back_d : front_q;
        pending_d  = commit ? 1'b0 : (pending_q | swap_req);

        segout_d   = scan_tick ? ~front_d[{scan_d, 3'b000} +: 8] : segout_q;

        frame_start_d = frame_wrap;
        swap_done_d   = commit;
    end

    // -----------------------------------------------------------------------
    // State registers. Reset leaves both buffers dark, the scan on row 0
    // with all pixels off, and the tie pointer favouring agent 0.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= 3'b000;
            rr_ptr_q      <= 1'b0;
            back_q        <= 64'd0;
            front_q       <= 64'd0;
            prescale_q    <= '0;
            scan_q        <= 3'd0;
            segout_q      <= 8'hFF;
            pending_q     <= 1'b0;
            swap_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            rr_ptr_q      <= rr_ptr_d;
            back_q        <= back_d;
            front_q       <= front_d;
            prescale_q    <= prescale_d;
            scan_q        <= scan_d;
            segout_q      <= segout_d;
            pending_q     <= pending_d;
            swap_done_q   <= swap_done_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign gnt         = gnt_q;
    assign swap_done   = swap_done_q;
    assign frame_start = frame_start_q;
    assign segout      = segout_q;
    assign scanout     = scan_q;

endmodule
